// File: rtl/fp_seq_pkg.sv
// Shared types for the fixed-point command sequencer: data constants, opcode,
// command record and sequencer state encoding.
package fp_seq_pkg;

   localparam int FP_N = 32;   // operand/result width, sign-magnitude
   localparam int FP_Q = 15;   // fraction bits

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_MUL = 2'd2,
      OP_DIV = 2'd3
   } opcode_t;

   typedef struct packed {
      logic [FP_N-1:0] a;
      logic [FP_N-1:0] b;
      opcode_t         op;
   } cmd_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP,
      S_DRAIN
   } state_t;

   function automatic cmd_t make_cmd(input logic [FP_N-1:0] a,
                                     input logic [FP_N-1:0] b,
                                     input logic [1:0]      op);
      cmd_t c;
      c.a  = a;
      c.b  = b;
      c.op = opcode_t'(op);
      return c;
   endfunction

endpackage

// File: rtl/fp_seq_fifo.sv
// Synchronous FIFO of sequencer commands with full/empty/occupancy.
// DEPTH must be a power of two (pointers wrap naturally), minimum 2.
module fp_seq_fifo
   import fp_seq_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  cmd_t                   wdata,
   output cmd_t                   rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("fp_seq_fifo: DEPTH must be a power of two and at least 2");
   end

   cmd_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // NOTE: storage has no reset; an entry is only ever read after being written, and count alone defines validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fp_cmd_sequencer.sv
// Issue stage for the fixed-point unit: queues commands, issues one at a time,
// returns each result on a valid/ready port. Optional watchdog: FP_SEQ_TIMEOUT_EN.
module fp_cmd_sequencer
   import fp_seq_pkg::*;
#(
   parameter int N           = FP_N,
   parameter int Q           = FP_Q,
   parameter int DEPTH       = 4,
   parameter int TIMEOUT_CYC = 64
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [N-1:0]           cmd_a,
   input  logic [N-1:0]           cmd_b,
   input  logic [1:0]             cmd_op,
   output logic [N-1:0]           alu_a,
   output logic [N-1:0]           alu_b,
   output logic [1:0]             alu_opcode,
   output logic                   alu_start,
   input  logic [N-1:0]           alu_c,
   input  logic                   alu_done,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [N-1:0]           rsp_c,
   output logic [1:0]             rsp_op,
   output logic                   rsp_err,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] fifo_count
);

   if (N != FP_N) begin : g_bad_n
      $error("fp_cmd_sequencer: N must match the packaged command width");
   end
   if (Q <= 0 || Q >= N) begin : g_bad_q
      $error("fp_cmd_sequencer: Q must leave room for sign and integer bits");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("fp_cmd_sequencer: TIMEOUT_CYC must be positive");
   end

   state_t state;
   cmd_t   head;
   logic   fifo_full;
   logic   fifo_empty;
   logic   do_pop;
   logic   ready_en;
   logic   expired;

   // Held low through reset and released one edge later so cmd_ready reads 0 while in reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ready_en <= 1'b0;
      else        ready_en <= 1'b1;
   end

   assign cmd_ready = ready_en && !fifo_full;
   assign do_pop    = (state == S_IDLE) && !fifo_empty;
   assign busy      = (state != S_IDLE) || !fifo_empty;

   fp_seq_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (cmd_valid && cmd_ready),
      .pop   (do_pop),
      .wdata (make_cmd(cmd_a, cmd_b, cmd_op)),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

`ifdef FP_SEQ_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0] wait_cnt;

   // Zero in the first WAIT cycle, so expiry falls after exactly TIMEOUT_CYC WAIT cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 wait_cnt <= '0;
      else if (state == S_ISSUE)  wait_cnt <= '0;
      else if (state == S_WAIT)   wait_cnt <= wait_cnt + 1'b1;
   end

   assign expired = (state == S_WAIT) && (wait_cnt == CW'(TIMEOUT_CYC - 1));
`else
   assign expired = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_opcode <= '0;
         alu_start  <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_c      <= '0;
         rsp_op     <= '0;
         rsp_err    <= 1'b0;
      end else begin
         alu_start <= 1'b0;
         case (state)
            S_IDLE: begin
               if (!fifo_empty) begin
                  alu_a      <= head.a;
                  alu_b      <= head.b;
                  alu_opcode <= head.op;
                  alu_start  <= 1'b1;
                  state      <= S_ISSUE;
               end
            end
            // A done seen here belongs to nothing we issued yet, so it is not examined.
            S_ISSUE: state <= S_WAIT;
            S_WAIT: begin
               if (alu_done || expired) begin
                  rsp_c     <= alu_done ? alu_c : '0;
                  rsp_err   <= !alu_done;
                  rsp_op    <= alu_opcode;
                  rsp_valid <= 1'b1;
                  state     <= S_RESP;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= alu_done ? S_DRAIN : S_IDLE;
               end
            end
            // Wait out a still-high done level so it cannot complete the next command.
            S_DRAIN: if (!alu_done) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_cmd_sequencer.sv
// Randomised self-checking bench: a transaction-level queue model of the
// sequencer plus a behavioural fixed-point unit with programmable latency.
module tb_fp_cmd_sequencer;
   import fp_seq_pkg::*;

   localparam int DEPTH = 4;
   localparam int TO    = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_a = '0;
   logic [31:0] cmd_b = '0;
   logic [1:0]  cmd_op = '0;
   logic [31:0] alu_a, alu_b;
   logic [1:0]  alu_opcode;
   logic        alu_start;
   logic [31:0] alu_c = '0;
   logic        alu_done = 1'b0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_c;
   logic [1:0]  rsp_op;
   logic        rsp_err;
   logic        busy;
   logic [2:0]  fifo_count;

   always #5 clk = ~clk;

   fp_cmd_sequencer #(
      .N(32), .Q(15), .DEPTH(DEPTH), .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_start(alu_start),
      .alu_c(alu_c), .alu_done(alu_done),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_c(rsp_c), .rsp_op(rsp_op), .rsp_err(rsp_err),
      .busy(busy), .fifo_count(fifo_count)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  op;
      bit          to;   // unit will never answer this one
   } tcmd_t;

   tcmd_t iss_q[$];
   tcmd_t rsp_q[$];
   int    start_log[$];
   int    n_push   = 0;
   int    n_start  = 0;
   int    cyc      = 0;
   int    push_cyc = 0;

   int    unit_lat  = 1;
   int    unit_hold = 1;
   bit    unit_rand = 1'b0;
   int    rdy_mode  = 1;      // 0 low, 1 high, 2 random
   bit    next_to   = 1'b0;

   // Stand-in arithmetic; the sequencer must return it bit-for-bit.
   function automatic logic [31:0] unit_fn(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
      case (op)
         2'd0:    return a + b;
         2'd1:    return a - b;
         2'd2:    return a ^ b;
         default: return ~a;
      endcase
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       rsp_ready = 1'b0;
         1:       rsp_ready = 1'b1;
         default: rsp_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Behavioural unit plus transaction monitor, all on the falling edge.
   bit          pend = 1'b0;
   bit          prev_start = 1'b0;
   int          lat_cnt, hold_cnt, pend_hold;
   logic [31:0] pend_c;

   always @(negedge clk) begin
      logic  done_at_edge;
      tcmd_t t;
      if (!rst_n) begin
         pend       = 1'b0;
         alu_done   = 1'b0;
         alu_c      = '0;
         prev_start = 1'b0;
      end else begin
         done_at_edge = alu_done;
         if (pend) begin
            lat_cnt--;
            if (lat_cnt <= 0) begin
               pend     = 1'b0;
               alu_done = 1'b1;
               alu_c    = pend_c;
               hold_cnt = pend_hold;
            end
         end else if (alu_done) begin
            hold_cnt--;
            if (hold_cnt <= 0) alu_done = 1'b0;
         end

         if (alu_start) begin
            check("start_one_cycle", prev_start, 0);
            check("start_after_done_low", done_at_edge, 0);
            if (iss_q.size() == 0) begin
               check("start_spurious", 1, 0);
            end else begin
               t = iss_q.pop_front();
               check("alu_a", alu_a, t.a);
               check("alu_b", alu_b, t.b);
               check("alu_opcode", alu_opcode, t.op);
               if (!t.to) begin
                  pend      = 1'b1;
                  lat_cnt   = unit_rand ? $urandom_range(1, 4) : unit_lat;
                  pend_hold = unit_rand ? $urandom_range(1, 3) : unit_hold;
                  pend_c    = unit_fn(t.a, t.b, t.op);
               end
            end
            n_start++;
            start_log.push_back(cyc);
         end
         prev_start = alu_start;

         check("fifo_count", fifo_count, n_push - n_start);
         check("cmd_ready", cmd_ready, (n_push - n_start) < DEPTH);

         if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
               check("rsp_spurious", 1, 0);
            end else begin
               t = rsp_q[0];
               check("rsp_c", rsp_c, t.to ? 32'h0 : unit_fn(t.a, t.b, t.op));
               check("rsp_op", rsp_op, t.op);
               check("rsp_err", rsp_err, t.to);
               if (rsp_ready) void'(rsp_q.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Leaves cmd_valid high so consecutive calls push on consecutive cycles.
   task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
      tcmd_t t;
      int    guard = 0;
      cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
      while (!cmd_ready && guard < 200) begin
         tick();
         guard++;
      end
      if (!cmd_ready) begin
         check("push_stall", 0, 1);
         cmd_valid = 1'b0;
         return;
      end
      tick();
      t = '{a, b, op, next_to};
      iss_q.push_back(t);
      rsp_q.push_back(t);
      n_push++;
      push_cyc = cyc;
   endtask

   task automatic wait_idle(input int bound);
      int g = 0;
      cmd_valid = 1'b0;
      while ((rsp_q.size() != 0 || iss_q.size() != 0 || busy) && g < bound) begin
         tick();
         g++;
      end
      check("idle_reached", g < bound, 1);
   endtask

   task automatic wait_rsp(output int at);
      int g = 0;
      while (!rsp_valid && g < 200) begin
         tick();
         g++;
      end
      check("rsp_arrived", rsp_valid, 1);
      at = cyc;
   endtask

   initial begin
      int at, s;
      #12;
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_alu_start", alu_start, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_fifo_count", fifo_count, 0);
      check("rst_busy", busy, 0);
      check("rst_rsp_c", rsp_c, 0);
      #11 rst_n = 1'b1;
      tick();
      check("ready_after_reset", cmd_ready, 1);

      // Single command, three-cycle unit.
      unit_lat = 3; unit_hold = 1; rdy_mode = 1;
      push(32'h0000C000, 32'h00012000, 2'd0);
      cmd_valid = 1'b0;
      wait_rsp(at);
      check("start_latency", start_log[start_log.size()-1] - push_cyc, 1);
      check("rsp_latency_lat3", at - push_cyc, 5);
      wait_idle(100);

      // Negative operand and negative zero pass through untouched.
      unit_lat = 1;
      push(32'h80008000, 32'h0, 2'd0);
      cmd_valid = 1'b0;
      wait_rsp(at);
      check("rsp_latency_min", at - push_cyc, 3);
      wait_idle(100);
      push(32'h80000000, 32'h0, 2'd1);
      wait_idle(100);

      // Back-to-back throughput.
      push(32'h1, 32'h2, 2'd0);
      push(32'h3, 32'h4, 2'd2);
      push(32'h5, 32'h6, 2'd3);
      wait_idle(100);
      s = start_log.size();
      check("throughput_1", start_log[s-2] - start_log[s-3], 4);
      check("throughput_2", start_log[s-1] - start_log[s-2], 4);

      // Fill with responses blocked.
      rdy_mode = 0;
      for (int i = 0; i < 5; i++) push(32'h100 + i, 32'h10 * i, 2'(i));
      tick();
      check("fill_count", fifo_count, 4);
      check("fill_ready", cmd_ready, 0);
      cmd_a = 32'hDEAD; cmd_valid = 1'b1;
      repeat (3) tick();
      check("fill_no_accept", fifo_count, 4);
      cmd_valid = 1'b0;
      rdy_mode = 1;
      wait_idle(200);

      // Back-pressure while done stays high, then DRAIN.
      rdy_mode = 0; unit_lat = 2; unit_hold = 25;
      push(32'h00018000, 32'h00008000, 2'd1);
      push(32'h7, 32'h9, 2'd0);
      cmd_valid = 1'b0;
      wait_rsp(at);
      repeat (10) begin
         tick();
         check("bp_valid_held", rsp_valid, 1);
      end
      rdy_mode = 1;
      for (int g = 0; g < 10 && rsp_valid; g++) tick();
      check("bp_done_still_high", alu_done, 1);
      for (int g = 0; g < 50 && alu_done; g++) begin
         check("no_start_in_drain", alu_start, 0);
         tick();
      end
      wait_idle(200);

      // Random traffic.
      unit_rand = 1'b1; rdy_mode = 2;
      for (int i = 0; i < 40; i++) begin
         push($urandom, $urandom, 2'($urandom_range(0, 3)));
         if ($urandom_range(0, 1) == 1) begin
            cmd_valid = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
         end
      end
      wait_idle(2000);
      unit_rand = 1'b0; rdy_mode = 1; unit_lat = 1; unit_hold = 1;

`ifdef FP_SEQ_TIMEOUT_EN
      // Unit never answers the first command; the second must run normally.
      next_to = 1'b1;
      push(32'h00020000, 32'h00010000, 2'd2);
      next_to = 1'b0;
      push(32'h00030000, 32'h00001000, 2'd0);
      cmd_valid = 1'b0;
      for (int g = 0; g < 50 && iss_q.size() > 1; g++) tick();
      s = start_log[start_log.size()-1];
      wait_rsp(at);
      check("timeout_latency", at - s, TO + 1);
      check("timeout_err", rsp_err, 1);
      wait_idle(200);
`endif

      // Reset during WAIT with two commands queued.
      unit_lat = 30;
      begin
         int n0;
         n0 = n_start;
         push(32'h11, 32'h22, 2'd0);
         push(32'h33, 32'h44, 2'd1);
         push(32'h55, 32'h66, 2'd2);
         cmd_valid = 1'b0;
         for (int g = 0; g < 20 && n_start == n0; g++) tick();
      end
      tick();
      check("pre_reset_count", fifo_count, 2);
      rst_n = 1'b0;
      #1;
      check("arst_alu_start", alu_start, 0);
      check("arst_fifo_count", fifo_count, 0);
      check("arst_busy", busy, 0);
      check("arst_alu_a", alu_a, 0);
      check("arst_cmd_ready", cmd_ready, 0);
      iss_q.delete(); rsp_q.delete();
      n_push = 0; n_start = 0;
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      unit_lat = 1;
      repeat (10) tick();
      check("no_start_after_reset", n_start, 0);
      check("idle_after_reset", busy, 0);
      push(32'h0000C000, 32'h00004000, 2'd0);
      wait_idle(100);
      check("start_after_new_push", n_start, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
      $fatal(1, "watchdog");
   end

endmodule
